// File: rtl/bit_serial_add_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : bit_serial_add_ctrl (with helper cell bit_serial_fa)     |
// | Description : WIDTH-bit adder built from one full-adder cell, LSB      |
// |               first, one bit per clock, with a start/done handshake.   |
// |               Optional subtract mode is enabled by defining the macro  |
// |               BIT_SERIAL_ADD_SUB_EN (adds the 'sub' input port).       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+

// One-bit full adder cell shared by the bit-serial sequencer.
module bit_serial_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);
endmodule

module bit_serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef BIT_SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   sum_sh_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   a_sh_d;
  logic [WIDTH-1:0]   b_sh_d;
  logic [WIDTH-1:0]   sum_sh_d;
  logic [WIDTH-1:0]   b_load_d;
  logic               carry_load_d;
  logic               last_bit;

  // The cell always sees the current LSBs and the running carry; its output
  // is only consumed while in RUN.
  bit_serial_fa u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign a_sh_d   = a_sh_q >> 1;
  assign b_sh_d   = b_sh_q >> 1;
  assign sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef BIT_SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1; the injected carry replaces cin.
  assign b_load_d     = sub ? ~b : b;
  assign carry_load_d = sub ? 1'b1 : cin;
`else
  assign b_load_d     = b;
  assign carry_load_d = cin;
`endif

  // Sequencer: captures operands, steps one bit per clock, publishes result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b_load_d;
            carry_q <= carry_load_d;
            cnt_q   <= '0;
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_d;
          b_sh_q   <= b_sh_d;
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_carry;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            // The final bit lands in the result directly, not via sum_sh_q.
            sum_q   <= sum_sh_d;
            cout_q  <= fa_carry;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_add_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_bit_serial_add_ctrl                                   |
// | Description : Self-checking bench for bit_serial_add_ctrl against an   |
// |               arithmetic reference model ({cout,sum} = a + b + cin).   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_bit_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         sub;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks;
  int n_errors;

  // Model of the held result register (what sum/cout must show outside DONE).
  logic [W-1:0] model_sum;
  logic         model_cout;

  bit_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef BIT_SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: plain (W+1)-bit addition.
  function automatic logic [W:0] ref_result(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                            input logic tcin, input logic tsub);
    logic [W:0] r;
    if (tsub) r = {1'b0, ta} + {1'b0, ~tb} + (W+1)'(1);
    else      r = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};
    return r;
  endfunction

  // One full operation from IDLE; called at #1 after a rising edge.
  // While busy, start and operands are scrambled to prove they are ignored.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
    logic [W:0] exp;
    int busyc;
    int lat;
    int donec;
    int hold_bad;
    exp = ref_result(ta, tb, tcin, tsub);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    busyc = 0; lat = -1; donec = 0; hold_bad = 0;
    while (busy && busyc < 100) begin
      busyc++;
      if (done) begin
        donec++;
        lat = busyc - 1;
      end else if (sum !== model_sum || cout !== model_cout) begin
        hold_bad++;
      end
      if (done && (sum !== exp[W-1:0] || cout !== exp[W])) hold_bad += 1000;
      start = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(W));
    check({tag, " busy_cycles"}, 64'(busyc), 64'(W + 1));
    check({tag, " done_pulses"}, 64'(donec), 64'd1);
    check({tag, " hold_and_done_value"}, 64'(hold_bad), 64'd0);
    model_sum = exp[W-1:0];
    model_cout = exp[W];
    // Stays idle with stable result until start is reasserted.
    repeat (3) @(posedge clk);
    #1;
    check({tag, " sum"}, 64'(sum), 64'(exp[W-1:0]));
    check({tag, " cout"}, 64'(cout), 64'(exp[W]));
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int done_at[$];
    int stable_bad;
    int drain;

    n_checks = 0; n_errors = 0;
    model_sum = '0; model_cout = 1'b0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
    rst_n = 1'b1;

    // Directed arithmetic cases.
    run_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("a5+5a+1", 8'hA5, 8'h5A, 1'b1, 1'b0);
    run_op("3c+0f", 8'h3C, 8'h0F, 1'b0, 1'b0);
    run_op("12+34", 8'h12, 8'h34, 1'b0, 1'b0);

    // Asynchronous reset mid-operation abandons it immediately.
    a = 8'h80; b = 8'h80; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst busy", 64'(busy), 64'd0);
    check("async_rst done", 64'(done), 64'd0);
    check("async_rst sum", 64'(sum), 64'd0);
    check("async_rst cout", 64'(cout), 64'd0);
    model_sum = '0; model_cout = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("post_rst 01+02", 8'h01, 8'h02, 1'b0, 1'b0);

    // Back-to-back with start held high: one result every W+2 cycles.
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    stable_bad = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done) done_at.push_back(cyc);
      if (done_at.size() > 0 && (sum !== 8'h30 || cout !== 1'b0)) stable_bad++;
    end
    start = 1'b0;
    check("b2b pulses", 64'(done_at.size()), 64'd4);
    for (int i = 1; i < done_at.size(); i++)
      check("b2b period", 64'(done_at[i] - done_at[i-1]), 64'(W + 2));
    check("b2b sum_stable", 64'(stable_bad), 64'd0);
    drain = 0;
    while (busy && drain < 50) begin
      @(posedge clk); #1;
      drain++;
    end
    check("b2b drain", 64'(busy), 64'd0);
    model_sum = 8'h30; model_cout = 1'b0;

`ifdef BIT_SERIAL_ADD_SUB_EN
    run_op("sub 05-07", 8'h05, 8'h07, 1'b0, 1'b1);
    run_op("sub 07-05", 8'h07, 8'h05, 1'b1, 1'b1);
`endif

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i == 0) begin ra = 8'hFF; rb = 8'hFF; end
`ifdef BIT_SERIAL_ADD_SUB_EN
      run_op("rand", ra, rb, 1'($urandom), 1'($urandom));
`else
      run_op("rand", ra, rb, 1'($urandom), 1'b0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
